// File: rtl/vip_pkg.sv
// Shared types and helpers for the Video_Image_Processor 3x3 matrix control path.
package vip_pkg;

  localparam int unsigned VIP_CW = 10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_IN_LINE   = 2'd2,
    ST_FRAME_END = 2'd3
  } vip_state_e;

  function automatic logic [1:0] BANK_NEXT(input logic [1:0] b);
    return (b == 2'd2) ? 2'd0 : b + 2'd1;
  endfunction

endpackage

// File: rtl/vip_edge_det.sv
// Registers a strobe once and flags its rising/falling edges against the live input.
module vip_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= din;
  end

  assign rise = din & ~q;
  assign fall = ~din & q;

endmodule

// File: rtl/vip_matrix_window_ctrl.sv
// Frame-timing controller for the 3x3 matrix: line RAM write/bank control,
// window-valid generation and sticky line/frame length error flags.
module vip_matrix_window_ctrl
  import vip_pkg::*;
#(
  parameter logic [VIP_CW-1:0] IMG_HDISP = 10'd640,
  parameter logic [VIP_CW-1:0] IMG_VDISP = 10'd480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic              err_clr,
  output logic              lb_wr_en,
  output logic [VIP_CW-1:0] lb_addr,
  output logic [1:0]        lb_wr_bank,
  output logic [1:0]        lb_rd_top,
  output logic [1:0]        lb_rd_mid,
  output logic              win_valid,
  output logic [VIP_CW-1:0] win_row,
  output logic [VIP_CW-1:0] win_col,
  output logic              frame_done,
  output logic              err_line,
  output logic              err_frame,
  output logic [1:0]        state
);

  vip_state_e        st;
  logic [VIP_CW-1:0] col_cnt, line_cnt, line_nxt, pix_col;
  logic              vs_q, vs_rise, vs_fall, hr_q, hr_rise, hr_fall;
  logic              pix_acc, pix_take, pix_in_img;
  logic              edge_unused;

  vip_edge_det u_vsync_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (per_frame_vsync),
    .q    (vs_q),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  vip_edge_det u_href_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (per_frame_href),
    .q    (hr_q),
    .rise (hr_rise),
    .fall (hr_fall)
  );

  assign edge_unused = vs_q ^ vs_fall ^ hr_q;

  assign state     = st;
  assign lb_rd_top = BANK_NEXT(lb_wr_bank);
  assign lb_rd_mid = BANK_NEXT(BANK_NEXT(lb_wr_bank));

  // A pixel coinciding with the href rising edge is column 0 of the new line,
  // so the accept path also runs in WAIT_LINE on that edge.
  always_comb begin
    pix_acc    = per_frame_href & per_frame_clken & ~per_frame_vsync;
    pix_col    = (st == ST_IN_LINE) ? col_cnt : '0;
    pix_take   = pix_acc & ~vs_rise &
                 ((st == ST_IN_LINE) | ((st == ST_WAIT_LINE) & hr_rise));
    pix_in_img = (pix_col < IMG_HDISP) && (line_cnt < IMG_VDISP);
    line_nxt   = line_cnt + 10'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      col_cnt    <= '0;
      line_cnt   <= '0;
      lb_wr_bank <= '0;
      lb_wr_en   <= 1'b0;
      lb_addr    <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
      err_line   <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      lb_wr_en   <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      // Clear first so a same-cycle error set below takes priority.
      if (err_clr) begin
        err_line  <= 1'b0;
        err_frame <= 1'b0;
      end
      if (vs_rise) begin
        col_cnt    <= '0;
        line_cnt   <= '0;
        lb_wr_bank <= '0;
        if (st != ST_IDLE && line_cnt != IMG_VDISP) err_frame <= 1'b1;
        st <= ST_WAIT_LINE;
      end else begin
        case (st)
          ST_WAIT_LINE: begin
            if (hr_rise && !per_frame_vsync) begin
              st      <= ST_IN_LINE;
              col_cnt <= '0;
            end
          end
          ST_IN_LINE: begin
            if (hr_fall) begin
              if (col_cnt != IMG_HDISP) err_line <= 1'b1;
              line_cnt   <= line_nxt;
              lb_wr_bank <= BANK_NEXT(lb_wr_bank);
              if (line_nxt == IMG_VDISP) begin
                frame_done <= 1'b1;
                st         <= ST_FRAME_END;
              end else begin
                st <= ST_WAIT_LINE;
              end
            end
          end
          default: ;
        endcase
        if (pix_take) begin
          col_cnt <= (pix_col == '1) ? pix_col : pix_col + 10'd1;
          if (pix_in_img) begin
            lb_wr_en <= 1'b1;
            lb_addr  <= pix_col;
            if (line_cnt >= 10'd2 && pix_col >= 10'd2) begin
              win_valid <= 1'b1;
              win_row   <= line_cnt - 10'd1;
              win_col   <= pix_col - 10'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vip_matrix_window_ctrl.sv
// Directed bench for vip_matrix_window_ctrl on a 6x4 image: frame-level vector
// table plus hand-written error-priority and mid-frame reset sequences.
module tb_vip_matrix_window_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic       clken = 1'b0;
  logic       err_clr = 1'b0;
  logic       lb_wr_en, win_valid, frame_done, err_line, err_frame;
  logic [9:0] lb_addr, win_row, win_col;
  logic [1:0] lb_wr_bank, lb_rd_top, lb_rd_mid, state;

  always #5 clk = ~clk;

  vip_matrix_window_ctrl #(.IMG_HDISP(10'd6), .IMG_VDISP(10'd4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .per_frame_vsync(vsync),
    .per_frame_href (href),
    .per_frame_clken(clken),
    .err_clr        (err_clr),
    .lb_wr_en       (lb_wr_en),
    .lb_addr        (lb_addr),
    .lb_wr_bank     (lb_wr_bank),
    .lb_rd_top      (lb_rd_top),
    .lb_rd_mid      (lb_rd_mid),
    .win_valid      (win_valid),
    .win_row        (win_row),
    .win_col        (win_col),
    .frame_done     (frame_done),
    .err_line       (err_line),
    .err_frame      (err_frame),
    .state          (state)
  );

  typedef struct {
    int nl;
    int p0, p1, p2, p3, p4;
    bit gap;
    int wr, win, fd, el, ef;
  } rec_t;

  rec_t recs[7];
  int   n_checks = 0, n_fail = 0;
  int   n_wr, n_win, n_fd, max_addr, max_wcol, first_row, first_col;
  int   bank_tab[4] = '{0, 1, 2, 0};
  int   top_tab[4]  = '{1, 2, 0, 1};
  int   mid_tab[4]  = '{2, 0, 1, 2};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_wr = 0; n_win = 0; n_fd = 0;
    max_addr = -1; max_wcol = -1; first_row = -1; first_col = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (lb_wr_en) begin
      n_wr++;
      if (int'(lb_addr) > max_addr) max_addr = int'(lb_addr);
    end
    if (win_valid) begin
      if (n_win == 0) begin
        first_row = int'(win_row);
        first_col = int'(win_col);
      end
      n_win++;
      if (int'(win_col) > max_wcol) max_wcol = int'(win_col);
    end
    if (frame_done) n_fd++;
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1; tick(); tick();
    vsync = 1'b0; tick(); tick();
  endtask

  task automatic send_line(input int npix, input bit gap, input bit clr_fall,
                           input int ln, input int exp_el);
    int cyc;
    cyc = (npix == 0) ? 1 : (gap ? 2 * npix : npix);
    href = 1'b1;
    for (int c = 0; c < cyc; c++) begin
      clken = gap ? ((c % 2 == 0) && npix > 0) : (c < npix);
      tick();
      if (c == 0 && ln >= 0 && ln < 4) begin
        chk($sformatf("bank_l%0d", ln), int'(lb_wr_bank), bank_tab[ln]);
        chk($sformatf("rd_top_l%0d", ln), int'(lb_rd_top), top_tab[ln]);
        chk($sformatf("rd_mid_l%0d", ln), int'(lb_rd_mid), mid_tab[ln]);
      end
    end
    href = 1'b0; clken = 1'b0; err_clr = clr_fall;
    tick();
    err_clr = 1'b0;
    if (exp_el >= 0) chk($sformatf("err_line_fall_l%0d", ln), int'(err_line), exp_el);
    tick(); tick();
  endtask

  task automatic run_rec(input rec_t r, input int idx);
    int pa[5];
    pa = '{r.p0, r.p1, r.p2, r.p3, r.p4};
    vsync_pulse();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    clear_mon();
    for (int l = 0; l < r.nl; l++) send_line(pa[l], r.gap, 1'b0, l, -1);
    vsync_pulse();
    chk($sformatf("r%0d_writes", idx), n_wr, r.wr);
    chk($sformatf("r%0d_windows", idx), n_win, r.win);
    chk($sformatf("r%0d_frame_done", idx), n_fd, r.fd);
    chk($sformatf("r%0d_err_line", idx), int'(err_line), r.el);
    chk($sformatf("r%0d_err_frame", idx), int'(err_frame), r.ef);
    chk($sformatf("r%0d_max_addr", idx), max_addr, 5);
    chk($sformatf("r%0d_max_wcol", idx), max_wcol, 4);
    chk($sformatf("r%0d_first_row", idx), first_row, 1);
    chk($sformatf("r%0d_first_col", idx), first_col, 1);
  endtask

  initial begin
    //          nl  p0 p1 p2 p3 p4 gap  wr win fd el ef
    recs[0] = '{4,  6, 6, 6, 6, 0, 1'b0, 24, 8, 1, 0, 0};
    recs[1] = '{4,  6, 5, 6, 6, 0, 1'b0, 23, 8, 1, 1, 0};
    recs[2] = '{4,  6, 6, 8, 6, 0, 1'b0, 24, 8, 1, 1, 0};
    recs[3] = '{3,  6, 6, 6, 0, 0, 1'b0, 18, 4, 0, 0, 1};
    recs[4] = '{5,  6, 6, 6, 6, 6, 1'b0, 24, 8, 1, 0, 0};
    recs[5] = '{4,  6, 0, 6, 6, 0, 1'b0, 18, 8, 1, 1, 0};
    recs[6] = '{4,  6, 6, 6, 6, 0, 1'b1, 24, 8, 1, 0, 0};

    clear_mon();
    tick(); tick();
    chk("rst_state", int'(state), 0);
    chk("rst_wr_en", int'(lb_wr_en), 0);
    chk("rst_addr", int'(lb_addr), 0);
    chk("rst_bank", int'(lb_wr_bank), 0);
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_err_line", int'(err_line), 0);
    chk("rst_err_frame", int'(err_frame), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_rec(recs[i], i);

    // err_clr coinciding with a short line's falling edge must leave err_line set
    vsync_pulse();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    send_line(6, 1'b0, 1'b0, 0, 0);
    send_line(5, 1'b0, 1'b1, 1, 1);
    send_line(6, 1'b0, 1'b0, 2, 1);
    send_line(6, 1'b0, 1'b0, 3, 1);
    vsync_pulse();
    for (int l = 0; l < 4; l++) send_line(6, 1'b0, 1'b0, l, 1);
    vsync_pulse();
    chk("err_line_sticky", int'(err_line), 1);
    chk("err_frame_clean", int'(err_frame), 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_line_cleared", int'(err_line), 0);

    // reset in the middle of line 2, while a window is being emitted
    vsync_pulse();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    send_line(6, 1'b0, 1'b0, 0, 0);
    send_line(6, 1'b0, 1'b0, 1, 0);
    href = 1'b1; clken = 1'b1;
    tick(); tick(); tick();
    chk("midline_wr_en", int'(lb_wr_en), 1);
    chk("midline_win_valid", int'(win_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_state", int'(state), 0);
    chk("mrst_wr_en", int'(lb_wr_en), 0);
    chk("mrst_addr", int'(lb_addr), 0);
    chk("mrst_bank", int'(lb_wr_bank), 0);
    chk("mrst_win_valid", int'(win_valid), 0);
    chk("mrst_win_row", int'(win_row), 0);
    chk("mrst_win_col", int'(win_col), 0);
    href = 1'b0; clken = 1'b0;
    tick();
    chk("mrst_state_held", int'(state), 0);
    rst_n = 1'b1;
    tick(); tick();
    vsync_pulse();
    chk("post_rst_err_frame", int'(err_frame), 0);
    chk("post_rst_state", int'(state), 1);
    run_rec(recs[0], 99);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
